// File: rtl/exp_pkg.sv
// Shared widths, state encoding and job record for the exponent job issuer.
package exp_pkg;

  localparam int A_W = 8;
  localparam int N_W = 8;
  localparam int R_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } issuer_state_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [N_W-1:0] n;
  } exp_job_t;

endpackage

// File: rtl/exp_job_fifo.sv
// Job FIFO with head peek; pointers carry an extra wrap bit so full and empty differ.
module exp_job_fifo
  import exp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_push,
  input  exp_job_t i_wr_data,
  input  logic     i_pop,
  output exp_job_t o_head,
  output logic [AW:0] o_count
);

  exp_job_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/exp_job_issuer.sv
// Feeds queued (a, n) jobs to the exponent engine over go/done and returns
// each result, tagged with its operands, on a valid/ready port.
module exp_job_issuer
  import exp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023,
  localparam int CNT_W  = $clog2(TIMEOUT + 1),
  localparam int PEND_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [A_W-1:0]    job_a,
  input  logic [N_W-1:0]    job_n,
  output logic              go_o,
  output logic [A_W-1:0]    a_o,
  output logic [N_W-1:0]    n_o,
  input  logic              done_i,
  input  logic [R_W-1:0]    result_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [R_W-1:0]    res_value,
  output logic [A_W-1:0]    res_a,
  output logic [N_W-1:0]    res_n,
  output logic              res_timeout,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output issuer_state_t     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the source holds its payload stable while valid is high and not accepted.

  issuer_state_t    r_state;
  logic             r_go;
  logic [A_W-1:0]   r_a;
  logic [N_W-1:0]   r_n;
  logic             r_done_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_res_valid;
  logic [R_W-1:0]   r_res_value;
  logic [A_W-1:0]   r_res_a;
  logic [N_W-1:0]   r_res_n;
  logic             r_res_timeout;

  exp_job_t          w_head;
  exp_job_t          w_wr_job;
  logic [PEND_W-1:0] w_count;
  logic              w_push;
  logic              w_pop;
  logic              w_done_edge;

  assign job_ready   = (w_count < PEND_W'(DEPTH));
  assign w_push      = job_valid && job_ready;
  // The head stays queued while in flight, so pending counts it too.
  assign w_pop       = (r_state == HOLD) && res_ready;
  assign w_wr_job    = '{a: job_a, n: job_n};
  assign w_done_edge = done_i && !r_done_q;

  exp_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (w_wr_job),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_go          <= 1'b0;
      r_a           <= '0;
      r_n           <= '0;
      r_done_q      <= 1'b0;
      r_cnt         <= '0;
      r_res_valid   <= 1'b0;
      r_res_value   <= '0;
      r_res_a       <= '0;
      r_res_n       <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      r_done_q <= done_i;
      r_go     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_count != '0) begin
            r_state <= ISSUE;
            r_go    <= 1'b1;
            r_a     <= w_head.a;
            r_n     <= w_head.n;
            r_cnt   <= '0;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // Edge detection keeps a done level left over from the last job from completing this one.
          if (w_done_edge) begin
            r_state       <= HOLD;
            r_res_valid   <= 1'b1;
            r_res_value   <= result_i;
            r_res_timeout <= 1'b0;
            r_res_a       <= r_a;
            r_res_n       <= r_n;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state       <= HOLD;
            r_res_valid   <= 1'b1;
            r_res_value   <= '0;
            r_res_timeout <= 1'b1;
            r_res_a       <= r_a;
            r_res_n       <= r_n;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (res_ready) begin
            r_state     <= IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign go_o        = r_go;
  assign a_o         = r_a;
  assign n_o         = r_n;
  assign res_valid   = r_res_valid;
  assign res_value   = r_res_value;
  assign res_a       = r_res_a;
  assign res_n       = r_res_n;
  assign res_timeout = r_res_timeout;
  assign busy        = (r_state != IDLE);
  assign pending     = w_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_exp_job_issuer.sv
// Bench for exp_job_issuer: behavioural engine, go/result scoreboards, directed tables.
module tb_exp_job_issuer;
  import exp_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int M_PULSE = 0;
  localparam int M_LEVEL = 1;
  localparam int M_NEVER = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [7:0]    job_a = '0;
  logic [7:0]    job_n = '0;
  logic          go_o;
  logic [7:0]    a_o;
  logic [7:0]    n_o;
  logic          done_i = 1'b0;
  logic [15:0]   result_i = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [15:0]   res_value;
  logic [7:0]    res_a;
  logic [7:0]    res_n;
  logic          res_timeout;
  logic          busy;
  logic [2:0]    pending;
  issuer_state_t dbg_state;

  exp_job_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_a(job_a), .job_n(job_n),
    .go_o(go_o), .a_o(a_o), .n_o(n_o),
    .done_i(done_i), .result_i(result_i),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_a(res_a), .res_n(res_n), .res_timeout(res_timeout),
    .busy(busy), .pending(pending), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [15:0] go_q[$];
  int exp_lat = 7;
  int go_cyc  = 0;
  int go_cnt  = 0;
  int res_cnt = 0;
  logic prev_go = 1'b0;
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural engine ----------------
  int   eng_mode = M_PULSE;
  int   eng_lat  = 6;
  int   eng_t    = 0;
  logic eng_busy = 1'b0;
  logic [15:0] eng_res = '0;

  function automatic logic [15:0] pow16(input logic [7:0] a, input logic [7:0] n);
    logic [15:0] r;
    r = 16'd1;
    for (int i = 0; i < int'(n); i++) r = r * 16'(a);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      done_i   = 1'b0;
      eng_busy = 1'b0;
      eng_t    = 0;
    end else if (go_o) begin
      eng_busy = 1'b1;
      eng_t    = 0;
      eng_res  = pow16(a_o, n_o);
      result_i = 16'hdead;
      if (eng_mode != M_LEVEL) done_i = 1'b0;
    end else if (eng_busy) begin
      eng_t++;
      if (eng_mode == M_LEVEL && eng_t == 2) done_i = 1'b0;
      if (eng_mode != M_NEVER && eng_t == eng_lat) begin
        done_i   = 1'b1;
        result_i = eng_res;
      end else if (eng_mode == M_PULSE) begin
        done_i = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      prev_go = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (go_o) begin
        chk("go_width", 64'(prev_go), 64'd0);
        if (go_q.size() == 0) fail("unexpected_go");
        else chk("go_operands", 64'({a_o, n_o}), 64'(go_q.pop_front()));
        go_cyc = cyc;
        go_cnt++;
      end
      if (res_valid && !prev_rv) chk("res_latency", 64'(cyc - go_cyc), 64'(exp_lat));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) fail("unexpected_result");
        else chk("res_fields", 64'({res_timeout, res_value, res_a, res_n}), 64'(exp_q.pop_front()));
        res_cnt++;
      end
      prev_go = go_o;
      prev_rv = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input logic [7:0] a, input logic [7:0] n,
                          input logic [15:0] ev, input logic to);
    int b;
    b = 0;
    job_a = a;
    job_n = n;
    job_valid = 1'b1;
    @(negedge clk);
    while (!job_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!job_ready) fail("push_timeout");
    else begin
      exp_q.push_back({to, ev, a, n});
      go_q.push_back({a, n});
    end
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = 0;
    @(negedge clk);
    while (!(dbg_state == IDLE && pending == 0 && exp_q.size() == 0) && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (b >= budget) fail("wait_idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_go"}, 64'(go_o), 64'd0);
    chk({tag, "_a_o"}, 64'(a_o), 64'd0);
    chk({tag, "_n_o"}, 64'(n_o), 64'd0);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_value"}, 64'(res_value), 64'd0);
    chk({tag, "_res_a"}, 64'(res_a), 64'd0);
    chk({tag, "_res_n"}, 64'(res_n), 64'd0);
    chk({tag, "_res_timeout"}, 64'(res_timeout), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pending"}, 64'(pending), 64'd0);
    chk({tag, "_job_ready"}, 64'(job_ready), 64'd1);
    chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  n;
    logic [15:0] exp_v;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int snap_go;
    int snap_res;
    int b;
    tbl[0] = '{8'd2,   8'd10, 16'd1024};
    tbl[1] = '{8'd5,   8'd3,  16'd125};
    tbl[2] = '{8'd0,   8'd0,  16'd1};
    tbl[3] = '{8'd255, 8'd2,  16'd65025};
    tbl[4] = '{8'd1,   8'd7,  16'd1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // single job, pulse done after 6 cycles
    eng_mode = M_PULSE; eng_lat = 6; exp_lat = 7;
    push_job(8'd3, 8'd4, 16'd81, 1'b0);
    wait_idle(100);
    chk("t1_go_count", 64'(go_cnt), 64'd1);

    // five back-to-back jobs, ready drops after the fourth
    for (int i = 0; i < 5; i++) begin
      push_job(tbl[i].a, tbl[i].n, tbl[i].exp_v, 1'b0);
      if (i == 3) begin
        chk("t2_ready_full", 64'(job_ready), 64'd0);
        chk("t2_pending_full", 64'(pending), 64'd4);
      end
    end
    wait_idle(300);
    chk("t2_res_count", 64'(res_cnt), 64'd6);

    // result back-pressure
    res_ready = 1'b0;
    push_job(8'd6, 8'd2, 16'd36, 1'b0);
    push_job(8'd2, 8'd3, 16'd8, 1'b0);
    b = 0;
    @(negedge clk);
    while (!res_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!res_valid) fail("t3_res_valid_timeout");
    snap_go = go_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(res_valid), 64'd1);
      chk("t3_hold_fields", 64'({res_timeout, res_value, res_a, res_n}), {31'd0, 1'b0, 16'd36, 8'd6, 8'd2});
      chk("t3_hold_pending", 64'(pending), 64'd2);
      chk("t3_hold_no_go", 64'(go_cnt), 64'(snap_go));
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle(100);

    // engine never answers: timeout at the 15th WAIT cycle, then normal job
    eng_mode = M_NEVER; exp_lat = TIMEOUT + 1;
    push_job(8'd9, 8'd9, 16'd0, 1'b1);
    wait_idle(100);
    eng_mode = M_PULSE; eng_lat = 6; exp_lat = 7;
    push_job(8'd4, 8'd3, 16'd64, 1'b0);
    wait_idle(100);
    // done edge in the same cycle the timeout would fire: completion wins
    eng_lat = TIMEOUT; exp_lat = TIMEOUT + 1;
    push_job(8'd2, 8'd5, 16'd32, 1'b0);
    wait_idle(100);

    // level done left high from the previous job
    eng_mode = M_LEVEL; eng_lat = 6; exp_lat = 7;
    push_job(8'd3, 8'd3, 16'd27, 1'b0);
    wait_idle(100);
    chk("t5_done_left_high", 64'(done_i), 64'd1);
    snap_res = res_cnt;
    push_job(8'd7, 8'd2, 16'd49, 1'b0);
    wait_idle(100);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_single_result", 64'(res_cnt - snap_res), 64'd1);

    // asynchronous reset mid-WAIT with three jobs pending
    eng_mode = M_PULSE; eng_lat = 12; exp_lat = 13;
    push_job(8'd2, 8'd1, 16'd2, 1'b0);
    push_job(8'd3, 8'd1, 16'd3, 1'b0);
    push_job(8'd4, 8'd1, 16'd4, 1'b0);
    b = 0;
    @(negedge clk);
    while (dbg_state != WAIT && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (dbg_state != WAIT) fail("t6_wait_timeout");
    chk("t6_pending_before", 64'(pending), 64'd3);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    exp_q.delete();
    go_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    snap_res = res_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("t6_no_res_valid", 64'(res_valid), 64'd0);
      chk("t6_no_go", 64'(go_o), 64'd0);
    end
    chk("t6_no_results", 64'(res_cnt - snap_res), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp_job_issuer.md
# exp_job_issuer

Initiator side of the exponent FSMD's go/done handshake. It accepts (a, n) jobs from an upstream producer into a small FIFO and drives `go_o`, `a_o` and `n_o` into the exponent engine one job at a time. It waits for the engine's `sig_done`, captures the 16-bit result, and returns it tagged with its operands on a valid/ready result port. A timeout flags a stuck engine. It sits between the switch/button front end and the exponent FSMD, replacing manual go pulses.

## Interface
- `DEPTH`, 4: job FIFO depth; power of two, ≥2.
- `TIMEOUT`, 1023: WAIT cycles without completion before the job is failed.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `job_valid` in 1, `job_ready` out 1: job push handshake.
- `job_a` in 8, `job_n` in 8: base and exponent of the pushed job.
- `go_o` out 1: one-cycle start pulse to the engine.
- `a_o` out 8, `n_o` out 8: operands to the engine; held stable from the go cycle until the result is accepted.
- `done_i` in 1: engine done (the engine's `sig_done`); may be a pulse or a level.
- `result_i` in 16: engine result (the engine's `output_reg`).
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_value` out 16, `res_a` out 8, `res_n` out 8: result and the operands that produced it.
- `res_timeout` out 1: qualifies `res_valid`; set when the job timed out.
- `busy` out 1: state ≠ IDLE.
- `pending` out clog2(DEPTH+1): FIFO occupancy, including the in-flight job.

## Operation
- **Push rule:** a job is pushed on any edge where `job_valid && job_ready`.
- `job_ready = (pending < DEPTH)`. There is no bypass. A pop and a push in the same cycle while full is not allowed, because `job_ready` is already 0.
- The head entry stays in the FIFO until its result is accepted. It is popped on `res_valid && res_ready`.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
- **IDLE → ISSUE** when the FIFO is non-empty.
- **ISSUE:**
  - `go_o` = 1 for exactly this one cycle.
  - `a_o` and `n_o` are loaded from the head entry.
  - The timeout counter is cleared.
  - The next state is always WAIT.
- **WAIT:**
  - Completion is a rising edge of `done_i`: `done_i` = 1 and the registered previous value `done_q` = 0.
  - A level `done_i` left high from the previous job therefore never completes a new job early.
  - `done_q` is updated every cycle and reset to 0.
  - On completion: capture `result_i` into `res_value`, set `res_timeout` = 0, go to HOLD.
  - Otherwise, when the counter reaches `TIMEOUT`: `res_value` = 0, `res_timeout` = 1, go to HOLD.
  - Completion and timeout in the same cycle: completion wins.
- **HOLD:**
  - `res_valid` = 1.
  - `res_value`, `res_a`, `res_n` and `res_timeout` are stable until the handshake.
  - On `res_ready`: pop the FIFO and go to IDLE.
- **Width rule:** `res_value` carries `result_i` unmodified, 16-bit, with any engine wrap included. No saturation is applied here.
- **Reset (asynchronous, any state, including mid-WAIT):**
  - The FSM goes to IDLE and the FIFO is emptied.
  - All outputs return to 0, except `job_ready`, which is 1.
  - `done_q` = 0.
  - Jobs in progress are lost and no result is emitted for them.

## Timing
- Push at edge k with the FIFO empty and state IDLE:
  - ISSUE during cycle k+1, so `go_o` is high in k+1.
  - WAIT from k+2.
- A `done_i` rising edge sampled at edge m gives `res_valid` high from cycle m+1.
- A result accepted at edge r gives IDLE in r+1 and the next `go_o` in r+2.
- Minimum job-to-job spacing is therefore 4 cycles plus the engine latency.
- The timeout fires at the TIMEOUT-th WAIT cycle without completion. The counter is 10 bits at the default setting (sized clog2(TIMEOUT+1)).
- All outputs are registered except `job_ready`, `busy` and `pending`, which are decoded from registers.

## Structure
- **Package `exp_pkg`:**
  - `A_W` = 8, `N_W` = 8, `R_W` = 16.
  - State enum `issuer_state_t` {IDLE, ISSUE, WAIT, HOLD}.
  - Packed struct `exp_job_t` {a, n}.
- **Sub-module `exp_job_fifo`:**
  - Synchronous FIFO of `exp_job_t`, parameterised by `DEPTH`.
  - Head peek, pop, and a count output that feeds `pending`.
  - Wrap-around pointers with an extra MSB for full/empty detection.

## Test plan
Use a behavioural engine model with programmable latency and done style.
1. Push a=3, n=4; the model raises done after 6 cycles with 81 → one `go_o` pulse with `a_o`=3, `n_o`=4; `res_value`=81, `res_a`=3, `res_n`=4, `res_timeout`=0.
2. Push five jobs back-to-back, with `res_ready`=1 throughout:
   - The jobs are (2,10), (5,3), (0,0), (255,2), (1,7).
   - `job_ready` drops after the fourth push.
   - Results arrive in order: 1024, 125, 1, 65025, 1.
3. Hold `res_ready` low for 20 cycles after a result → `res_valid` stays high with stable fields, no new `go_o`, and `pending` unchanged.
4. With `TIMEOUT`=15, the model never raises done → `res_valid` at WAIT cycle 15 with `res_timeout`=1 and `res_value`=0; the next job then issues normally.
5. Level done:
   - `done_i` is held high from the previous job, drops 2 cycles after `go_o`, and rises again 4 cycles later with 49 for a=7, n=2.
   - Required: exactly one result, 49, with no early completion.
6. Assert `rst` low mid-WAIT with 3 jobs pending → outputs go to reset values immediately, `pending`=0, and no `res_valid` appears after release.
